// File: rtl/keypad_scanner.sv
// keypad_scanner: parametrised matrix-keypad scanner.
// Drives one active-low column at a time, samples active-low rows through a
// 2-flop synchroniser, and debounces press and release on prescaled scan ticks.
// Optional auto-repeat while a key is held is enabled by defining the macro
// KEYPAD_REPEAT_EN; without it exactly one valid_key pulse is produced per press.
//
// Output handshake: valid_key and key_release are single-cycle strobes with no
// back-pressure; key is stable from the valid_key cycle until the next accepted
// press, and key_held is level-high between acceptance and accepted release.
module keypad_scanner #(
    parameter int ROWS           = 3,
    parameter int COLS           = 3,
    parameter int SCAN_DIV       = 5464,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int REPEAT_DELAY   = 32,
    parameter int REPEAT_RATE    = 8,
    localparam int KEY_W         = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ROWS-1:0]  row,
    output logic [COLS-1:0]  column,
    output logic [KEY_W-1:0] key,
    output logic             valid_key,
    output logic             key_held,
    output logic             key_release
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = $clog2(COLS);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int DEB_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

    localparam logic [1:0] SCAN        = 2'd0;
    localparam logic [1:0] CONFIRM     = 2'd1;
    localparam logic [1:0] HELD        = 2'd2;
    localparam logic [1:0] REL_CONFIRM = 2'd3;

    // Reject illegal parameter sets at elaboration time.
    generate
        if (ROWS < 1 || COLS < 2 || SCAN_DIV < 2 || DEBOUNCE_TICKS < 1 ||
            REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
            $error("keypad_scanner: illegal parameter value");
        end
    endgenerate

    logic [ROWS-1:0]  row_s1_q, row_s1_d;
    logic [ROWS-1:0]  srow_q, srow_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [1:0]       state_q, state_d;
    logic [COL_W-1:0] col_idx_q, col_idx_d;
    logic [ROW_W-1:0] row_idx_q, row_idx_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             valid_q, valid_d;
    logic             held_q, held_d;
    logic             release_q, release_d;

    logic             tick;
    logic             any_low;
    logic [ROW_W-1:0] low_idx;
    logic [COL_W-1:0] col_next;
    logic             row_up;
    logic             deb_done;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_phase_q, rep_phase_d;
    logic [REP_W-1:0] rep_thr;
    logic [REP_W-1:0] rep_nxt;
`endif

    // Prescaler tick, lowest pressed row, and next column index.
    always_comb begin
        tick     = (presc_q == PRE_W'(SCAN_DIV - 1));
        presc_d  = tick ? '0 : presc_q + 1'b1;
        row_s1_d = row;
        srow_d   = row_s1_q;
        any_low  = 1'b0;
        low_idx  = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!srow_q[i]) begin
                any_low = 1'b1;
                low_idx = ROW_W'(i);
            end
        end
        col_next = (col_idx_q == COL_W'(COLS - 1)) ? '0 : col_idx_q + 1'b1;
        row_up   = srow_q[row_idx_q];
        deb_done = (deb_cnt_q == DEB_W'(DEBOUNCE_TICKS - 1));
    end

    // Scan / debounce state machine; every decision waits for a scan tick.
    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        row_idx_d = row_idx_q;
        deb_cnt_d = deb_cnt_q;
        key_d     = key_q;
        valid_d   = 1'b0;
        held_d    = held_q;
        release_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_phase_d = rep_phase_q;
        rep_thr     = rep_phase_q ? REP_W'(REPEAT_RATE) : REP_W'(REPEAT_DELAY);
        rep_nxt     = (rep_cnt_q >= rep_thr) ? rep_cnt_q : rep_cnt_q + 1'b1;
`endif
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (any_low) begin
                        row_idx_d = low_idx;
                        deb_cnt_d = '0;
                        state_d   = CONFIRM;
                    end else begin
                        col_idx_d = col_next;
                    end
                end
                CONFIRM: begin
                    if (!row_up) begin
                        if (deb_done) begin
                            state_d = HELD;
                            key_d   = KEY_W'(row_idx_q) * KEY_W'(COLS) + KEY_W'(col_idx_q);
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                        end else begin
                            deb_cnt_d = deb_cnt_q + 1'b1;
                        end
                    end else begin
                        state_d   = SCAN;
                        col_idx_d = col_next;
                    end
                end
                HELD: begin
                    if (row_up) begin
                        deb_cnt_d = '0;
                        state_d   = REL_CONFIRM;
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt_d = rep_nxt;
`endif
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        // Repeat delay then rate, both counted from acceptance.
                        if (rep_nxt >= rep_thr) begin
                            valid_d     = 1'b1;
                            rep_cnt_d   = '0;
                            rep_phase_d = 1'b1;
                        end else begin
                            rep_cnt_d = rep_nxt;
                        end
`endif
                    end
                end
                default: begin
                    if (row_up) begin
                        if (deb_done) begin
                            release_d = 1'b1;
                            held_d    = 1'b0;
                            col_idx_d = col_next;
                            state_d   = SCAN;
                        end else begin
                            deb_cnt_d = deb_cnt_q + 1'b1;
                        end
                    end else begin
                        state_d = HELD;
                    end
`ifdef KEYPAD_REPEAT_EN
                    // Keep counting through a release bounce so it does not restart the delay.
                    rep_cnt_d = rep_nxt;
`endif
                end
            endcase
        end
`ifdef KEYPAD_REPEAT_EN
        if (state_d == SCAN || state_d == CONFIRM) begin
            rep_cnt_d   = '0;
            rep_phase_d = 1'b0;
        end
`endif
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_s1_q  <= '1;
            srow_q    <= '1;
            presc_q   <= '0;
            state_q   <= SCAN;
            col_idx_q <= '0;
            row_idx_q <= '0;
            deb_cnt_q <= '0;
            key_q     <= '0;
            valid_q   <= 1'b0;
            held_q    <= 1'b0;
            release_q <= 1'b0;
        end else begin
            row_s1_q  <= row_s1_d;
            srow_q    <= srow_d;
            presc_q   <= presc_d;
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            row_idx_q <= row_idx_d;
            deb_cnt_q <= deb_cnt_d;
            key_q     <= key_d;
            valid_q   <= valid_d;
            held_q    <= held_d;
            release_q <= release_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
        end
    end
`endif

    assign column      = ~(COLS'(1) << col_idx_q);
    assign key         = key_q;
    assign valid_key   = valid_q;
    assign key_held    = held_q;
    assign key_release = release_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner.
// Instance A is 3x3, instance B is 4x4; both use SCAN_DIV=4, DEBOUNCE_TICKS=3.
// A keypad model shorts a row low only while its pressed key's column is driven.
// If KEYPAD_REPEAT_EN is defined, the long-hold step expects auto-repeat pulses.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       reset_a;
    logic       reset_b;
    logic [2:0] rows_a;
    logic [2:0] column_a;
    logic [3:0] key_a;
    logic       valid_a, held_a, rel_a;
    logic [3:0] rows_b;
    logic [3:0] column_b;
    logic [3:0] key_b;
    logic       valid_b, held_b, rel_b;

    logic [8:0]  press_a = '0;
    logic [15:0] press_b = '0;

    int cyc = 0;
    int vcnt_a = 0, rcnt_a = 0, vcnt_b = 0, rcnt_b = 0, overlap = 0;
    int checks = 0, passes = 0;

`ifdef KEYPAD_REPEAT_EN
    localparam int EXP_PULSES = 5;
`else
    localparam int EXP_PULSES = 1;
`endif

    keypad_scanner #(.ROWS(3), .COLS(3), .SCAN_DIV(4), .DEBOUNCE_TICKS(3),
                     .REPEAT_DELAY(6), .REPEAT_RATE(2)) dut_a (
        .clk(clk), .reset(reset_a), .row(rows_a), .column(column_a), .key(key_a),
        .valid_key(valid_a), .key_held(held_a), .key_release(rel_a)
    );

    keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_TICKS(3),
                     .REPEAT_DELAY(6), .REPEAT_RATE(2)) dut_b (
        .clk(clk), .reset(reset_b), .row(rows_b), .column(column_b), .key(key_b),
        .valid_key(valid_b), .key_held(held_b), .key_release(rel_b)
    );

    // Clock.
    always #5 clk = ~clk;

    // Keypad model: a pressed key pulls its row low while its column is low.
    always_comb begin
        rows_a = '1;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                if (press_a[r*3+c] && !column_a[c]) rows_a[r] = 1'b0;
        rows_b = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (press_b[r*4+c] && !column_b[c]) rows_b[r] = 1'b0;
    end

    // Cycle counter since release of reset_a, plus pulse counters.
    always @(posedge clk) begin
        if (reset_a) cyc <= 0;
        else         cyc <= cyc + 1;
        if (valid_a === 1'b1) vcnt_a <= vcnt_a + 1;
        if (rel_a === 1'b1)   rcnt_a <= rcnt_a + 1;
        if (valid_b === 1'b1) vcnt_b <= vcnt_b + 1;
        if (rel_b === 1'b1)   rcnt_b <= rcnt_b + 1;
        if ((valid_a === 1'b1 && rel_a === 1'b1) || (valid_b === 1'b1 && rel_b === 1'b1))
            overlap <= overlap + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        int n;
        int ca;
        int vbase;

        // Reset both instances for three cycles.
        reset_a = 1'b1;
        reset_b = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_column", 32'(column_a), 32'h6);
        check("rst_key", 32'(key_a), 32'h0);
        check("rst_valid", 32'(valid_a), 32'h0);
        check("rst_held", 32'(held_a), 32'h0);
        check("rst_release", 32'(rel_a), 32'h0);
        reset_a = 1'b0;
        reset_b = 1'b0;

        // Column walk, four clocks per step.
        wait_cyc(3);  check("col_step0", 32'(column_a), 32'h6);
        wait_cyc(4);  check("col_step1", 32'(column_a), 32'h5);
        wait_cyc(8);  check("col_step2", 32'(column_a), 32'h3);
        wait_cyc(12); check("col_wrap", 32'(column_a), 32'h6);

        // Press key 5 (row 1, column 2): accepted at cycle 36.
        press_a = 9'b1 << 5;
        wait_cyc(35); check("press_early", 32'(valid_a), 32'h0);
        wait_cyc(36);
        check("press_valid", 32'(valid_a), 32'h1);
        check("press_key", 32'(key_a), 32'h5);
        check("press_held", 32'(held_a), 32'h1);
        wait_cyc(37);
        check("press_pulse_end", 32'(valid_a), 32'h0);
        check("press_col_held", 32'(column_a), 32'h3);
        check("press_one_pulse", 32'(vcnt_a), 32'h1);

        // One-tick release bounce.
        wait_cyc(40); press_a = '0;
        wait_cyc(44); press_a = 9'b1 << 5;
        wait_cyc(49);
        check("bounce_held", 32'(held_a), 32'h1);
        check("bounce_no_rel", 32'(rcnt_a), 32'h0);
        check("bounce_column", 32'(column_a), 32'h3);

        // Real release: accepted at cycle 68.
        wait_cyc(52); press_a = '0;
        wait_cyc(67); check("rel_early", 32'(rel_a), 32'h0);
        wait_cyc(68);
        check("rel_pulse", 32'(rel_a), 32'h1);
        check("rel_held", 32'(held_a), 32'h0);
        check("rel_key_kept", 32'(key_a), 32'h5);
        check("rel_col_adv", 32'(column_a), 32'h6);
        wait_cyc(69);
        check("rel_pulse_end", 32'(rel_a), 32'h0);
        check("rel_no_valid", 32'(vcnt_a), 32'h1);

        // Key 0 seen for one confirming tick only: rejected, scan moves on.
        press_a = 9'b1;
        wait_cyc(76); press_a = '0;
        wait_cyc(79); check("glitch_col_hold", 32'(column_a), 32'h6);
        wait_cyc(80);
        check("glitch_col_adv", 32'(column_a), 32'h5);
        check("glitch_key", 32'(key_a), 32'h5);
        wait_cyc(100);
        check("glitch_no_valid", 32'(vcnt_a), 32'h1);

        // Long hold of key 7 (row 2, column 1).
        vbase = vcnt_a;
        press_a = 9'b1 << 7;
        n = 0;
        while (valid_a !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("hold_accept_timeout", 32'(n < 200), 32'h1);
        ca = cyc;
        check("hold_tick_aligned", 32'(ca % 4), 32'h0);
        check("hold_key", 32'(key_a), 32'h7);
        wait_cyc(ca + 52);
        check("hold_pulses", 32'(vcnt_a - vbase), 32'(EXP_PULSES));
        check("hold_key_same", 32'(key_a), 32'h7);
        press_a = '0;
        n = 0;
        while (rel_a !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hold_rel_timeout", 32'(n < 100), 32'h1);
        check("hold_rel_held", 32'(held_a), 32'h0);
        @(negedge clk);
        check("hold_rel_key", 32'(key_a), 32'h7);

        // 4x4: rows 3 and 2 on column 3, lowest row wins.
        press_b = (16'b1 << 11) | (16'b1 << 15);
        n = 0;
        while (valid_b !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("b_accept_timeout", 32'(n < 200), 32'h1);
        check("b_key", 32'(key_b), 32'hb);
        check("b_held", 32'(held_b), 32'h1);
        repeat (8) @(negedge clk);
        reset_b = 1'b1;
        press_b = '0;
        repeat (2) @(negedge clk);
        check("b_rst_held", 32'(held_b), 32'h0);
        check("b_rst_key", 32'(key_b), 32'h0);
        check("b_rst_column", 32'(column_b), 32'he);
        reset_b = 1'b0;
        repeat (40) @(negedge clk);
        check("b_no_release", 32'(rcnt_b), 32'h0);
        check("b_single_valid", 32'(vcnt_b), 32'h1);

        check("no_overlap", 32'(overlap), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Parametrised matrix-keypad scanner, successor to the fixed 3x3 keypad controller.
- Drives active-low columns one at a time and samples active-low rows through a synchroniser.
- Debounces both press and release with a tick-based state machine.
- Reports one key index per press, plus held and release indications, to the game logic.

Parameters:
ROWS, 3, number of row inputs (>=1)
COLS, 3, number of column outputs (>=2)
SCAN_DIV, 5464, clk cycles per scan tick (>=2)
DEBOUNCE_TICKS, 4, consecutive stable ticks required to accept a press or a release (>=1)
REPEAT_DELAY, 32, ticks held before the first auto-repeat (used only with KEYPAD_REPEAT_EN)
REPEAT_RATE, 8, ticks between auto-repeats (used only with KEYPAD_REPEAT_EN)
KEY_W (localparam), clog2(ROWS*COLS), key index width (min 1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
row  in  ROWS  raw keypad rows, active-low, asynchronous to clk
column  out  COLS  column drive, active-low, exactly one bit low at any time
key  out  KEY_W  index of the last accepted key = row_idx*COLS + col_idx
valid_key  out  1  one-cycle pulse when a key is accepted
key_held  out  1  high from acceptance until release is accepted
key_release  out  1  one-cycle pulse when release is accepted

Behaviour:
- One clock domain; all state updates on rising clk.
- Reset: synchronous, active-high, dominates all other activity.
- Reset values: state=SCAN, col_idx=0, column={ {COLS-1{1}},0 }, key=0, valid_key=0, key_held=0, key_release=0, prescaler=0, deb_cnt=0, row synchroniser=all ones.
- Reset mid-press: returns to SCAN with no release pulse.
- Row synchroniser: 2-flop, per bit. All decisions use the synchronised rows (srow).
- Prescaler: counts 0..SCAN_DIV-1 and wraps. tick=1 in the cycle where count==SCAN_DIV-1.
- All FSM decisions are made only on tick cycles.
- SCAN:
  - column=~(1<<col_idx).
  - On tick, if any srow bit is low: row_idx=lowest-index low bit, deb_cnt=0, go to CONFIRM; column unchanged.
  - On tick, otherwise: col_idx advances, wrapping from COLS-1 to 0.
- CONFIRM:
  - Column held.
  - On tick with srow[row_idx] low: if deb_cnt==DEBOUNCE_TICKS-1, go to HELD, else deb_cnt++.
  - On HELD entry, on the same edge: key<=row_idx*COLS+col_idx, valid_key<=1 for exactly one cycle, key_held<=1.
  - On tick with srow[row_idx] high: go to SCAN, col_idx advances, no output change.
- HELD:
  - Column held.
  - Other keys are ignored (single-key scanner).
  - On tick with srow[row_idx] high: deb_cnt=0, go to REL_CONFIRM.
- REL_CONFIRM:
  - On tick with srow[row_idx] high: if deb_cnt==DEBOUNCE_TICKS-1, then key_release<=1 for one cycle, key_held<=0, col_idx advances, go to SCAN. Otherwise deb_cnt++.
  - On tick with srow[row_idx] low: go to HELD, no pulse.
- Latency: from the SCAN tick that detects the press, valid_key asserts DEBOUNCE_TICKS ticks later, in the cycle after the last confirming tick.
- key retains its value after release until the next acceptance.
- valid_key and key_release are never high in the same cycle.
- Index arithmetic is done at KEY_W width; no overflow for legal parameters.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - In HELD, a repeat counter counts ticks from acceptance.
  - After REPEAT_DELAY ticks, valid_key re-pulses (one cycle, same key) and repeats every REPEAT_RATE ticks while the state remains HELD.
  - The counter is cleared on leaving HELD.
  - A HELD→REL_CONFIRM→HELD bounce does not restart the delay.
- Not defined:
  - Exactly one valid_key per accepted press.
  - REPEAT_* parameters exist but are unused, and no repeat logic is synthesised.

Test Plan:
All scenarios use ROWS=3, COLS=3, SCAN_DIV=4, DEBOUNCE_TICKS=3 unless stated.
1. Reset held for 3 cycles, then released, rows=3'b111 -> column=3'b110 and all outputs 0. Column then steps 110→101→011→110, each step 4 clk cycles long.
2. row[1] held low while column=3'b011 -> row seen after sync, 3 confirming ticks, then key=5 with a single 1-cycle valid_key and key_held=1. Column stays at 011 while held.
3. row[0] low for only 1 tick during CONFIRM -> no valid_key, key unchanged, and scanning resumes at the next column.
4. From scenario 2, rows go high for 1 tick then low again -> no key_release and key_held stays 1. Rows then high for 3 ticks -> one-cycle key_release, key_held=0, key still 5.
5. ROWS=4, COLS=4 (KEY_W=4), row[3] and row[2] low together on column 3 -> key=11 (lowest row wins). Reset asserted while held -> key_held=0 and no key_release.
6. KEYPAD_REPEAT_EN defined, REPEAT_DELAY=6, REPEAT_RATE=2, key held for 12 ticks after acceptance -> valid_key pulses at acceptance, +6, +8, +10 and +12 ticks, all with the same key.
